// File: rtl/mem_preloader.sv
// Program loader: parses framed DATA/FILL/GO records from a byte stream into RAM,
// then releases the CPU with the received start vector and hands it the RAM port.
module mem_preloader #(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [15:0] DEFAULT_VEC = 16'h0400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              cpu_run,
  output logic [15:0]       pc_vec,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        seg_count
);

  localparam int unsigned LEN_W = 16;

  typedef enum logic [3:0] {
    HDR, ADDR_L, ADDR_H, LEN_L, LEN_H, DATA, VAL, CSUM, FILL, VEC_L, VEC_H, RUN, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        val_q, val_d;
  logic [7:0]        vec_lo_q, vec_lo_d;
  logic [7:0]        seg_q, seg_d;
  logic              is_fill_q, is_fill_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       vec_q, vec_d;

  logic              hs;
  logic [7:0]        csum_sum;
  logic [LEN_W-1:0]  len_full;

  assign hs       = s_valid & ready_q;
  assign csum_sum = csum_q + s_data;
  assign len_full = {s_data, len_q[7:0]};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HDR;
      addr_q    <= '0;
      len_q     <= '0;
      csum_q    <= 8'h00;
      val_q     <= 8'h00;
      vec_lo_q  <= 8'h00;
      seg_q     <= 8'h00;
      is_fill_q <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 8'h00;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      vec_q     <= DEFAULT_VEC;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      val_q     <= val_d;
      vec_lo_q  <= vec_lo_d;
      seg_q     <= seg_d;
      is_fill_q <= is_fill_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      run_q     <= run_d;
      done_q    <= done_d;
      err_q     <= err_d;
      vec_q     <= vec_d;
    end
  end

  // Record parser: next state and registered outputs
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    csum_d    = csum_q;
    val_d     = val_q;
    vec_lo_d  = vec_lo_q;
    seg_d     = seg_q;
    is_fill_d = is_fill_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    run_d     = run_q;
    done_d    = done_q;
    err_d     = err_q;
    vec_d     = vec_q;

    if (hs) csum_d = csum_sum;

    case (state_q)
      HDR: if (hs) begin
        csum_d = 8'h00;
        case (s_data)
          8'h01: begin is_fill_d = 1'b0; state_d = ADDR_L; end
          8'h03: begin is_fill_d = 1'b1; state_d = ADDR_L; end
          8'h02: state_d = VEC_L;
          default: begin err_d = 1'b1; state_d = ERR; end
        endcase
      end
      ADDR_L: if (hs) begin
        addr_d  = ADDR_W'({8'h00, s_data});
        state_d = ADDR_H;
      end
      ADDR_H: if (hs) begin
        addr_d  = ADDR_W'({s_data, addr_q[7:0]});
        state_d = LEN_L;
      end
      LEN_L: if (hs) begin
        len_d   = {8'h00, s_data};
        state_d = LEN_H;
      end
      LEN_H: if (hs) begin
        len_d = len_full;
        if (is_fill_q)            state_d = VAL;
        else if (len_full != '0)  state_d = DATA;
        else                      state_d = CSUM;
      end
      DATA: if (hs) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = s_data;
        addr_d  = addr_q + ADDR_W'(1);
        len_d   = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1)) state_d = CSUM;
      end
      VAL: if (hs) begin
        val_d   = s_data;
        state_d = CSUM;
      end
      CSUM: if (hs) begin
        if (csum_sum == 8'h00) begin
          seg_d = (seg_q == 8'hFF) ? seg_q : seg_q + 8'd1;
          // First fill write issues on the csum edge so the run is exactly len cycles
          if (is_fill_q && len_q != '0) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = val_q;
            addr_d  = addr_q + ADDR_W'(1);
            len_d   = len_q - LEN_W'(1);
            state_d = FILL;
          end else begin
            state_d = HDR;
          end
        end else begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      FILL: begin
        if (len_q != '0) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = val_q;
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q - LEN_W'(1);
        end else begin
          state_d = HDR;
        end
      end
      VEC_L: if (hs) begin
        vec_lo_d = s_data;
        state_d  = VEC_H;
      end
      VEC_H: if (hs) begin
        vec_d   = {s_data, vec_lo_q};
        run_d   = 1'b1;
        done_d  = 1'b1;
        state_d = RUN;
      end
      RUN, ERR: ;
      default: state_d = HDR;
    endcase

    ready_d = !(state_d inside {FILL, RUN, ERR});
  end

  // RAM port belongs to the CPU once released
  assign mem_addr  = run_q ? cpu_addr  : waddr_q;
  assign mem_wdata = run_q ? cpu_wdata : wdata_q;
  assign mem_we    = run_q ? cpu_we    : we_q;

  assign s_ready   = ready_q;
  assign cpu_run   = run_q;
  assign pc_vec    = vec_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign seg_count = seg_q;

endmodule

// File: tb/tb_mem_preloader.sv
// Directed bench for mem_preloader: a record-level model predicts RAM writes and
// final flags; a per-cycle process checks every loader write against it.
module tb_mem_preloader;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_run;
  logic [15:0] pc_vec;
  logic        load_done;
  logic        load_err;
  logic [7:0]  seg_count;

  mem_preloader #(.ADDR_W(16), .DEFAULT_VEC(16'h0400)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_run(cpu_run), .pc_vec(pc_vec), .load_done(load_done),
    .load_err(load_err), .seg_count(seg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  stream[$];
  wr_t         m_wr[$];
  int          m_seg;
  logic        m_err;
  logic        m_done;
  logic [15:0] m_vec;
  int          m_accept;
  logic        data_mode = 1'b0;
  logic        hs_q = 1'b0;
  logic [7:0]  ram [0:65535];
  int          wr_cnt = 0;
  wr_t         w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_seg  = 0;
    m_err  = 1'b0;
    m_done = 1'b0;
    m_vec  = 16'h0400;
    m_wr.delete();
  endtask

  // Record-level model: walk whole records, stop at the first error or GO
  task automatic model_run();
    int i;
    int a;
    int n;
    int body;
    logic [7:0] t;
    logic [7:0] sum;
    i = 0;
    while (i < stream.size() && !m_err && !m_done) begin
      t = stream[i];
      if (t == 8'h01 || t == 8'h03) begin
        a    = 32'({stream[i+2], stream[i+1]});
        n    = 32'({stream[i+4], stream[i+3]});
        body = (t == 8'h01) ? n + 1 : 2;
        sum  = 8'h00;
        for (int k = 1; k <= 4 + body; k++) sum += stream[i+k];
        if (t == 8'h01)
          for (int k = 0; k < n; k++) m_wr.push_back({16'(a + k), stream[i+5+k]});
        if (sum == 8'h00) begin
          if (m_seg < 255) m_seg++;
          if (t == 8'h03)
            for (int k = 0; k < n; k++) m_wr.push_back({16'(a + k), stream[i+5]});
        end else begin
          m_err = 1'b1;
        end
        i += 5 + body;
      end else if (t == 8'h02) begin
        m_vec  = {stream[i+2], stream[i+1]};
        m_done = 1'b1;
        i += 3;
      end else begin
        m_err = 1'b1;
        i += 1;
      end
    end
    m_accept = i;
  endtask

  always @(posedge clk) begin
    hs_q <= s_valid && s_ready;
    if (mem_we && !cpu_run) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Every loader write must be the next one the model predicts
  always @(negedge clk) begin
    if (!rst && mem_we && !cpu_run) begin
      if (m_wr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_extra: got write %0h=%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        w = m_wr.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.a));
        check("wr_data", 32'(mem_wdata), 32'(w.d));
      end
      if (data_mode) check("wr_after_hs", 32'(hs_q), 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int t;
    int gap;
    t = 0;
    @(negedge clk);
    if (stall) begin
      gap = $urandom_range(0, 3);
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL hs_timeout: got no s_ready for byte %0h, expected handshake", b);
    end
    @(posedge clk);
  endtask

  task automatic run_stream(input bit stall);
    model_run();
    for (int i = 0; i < m_accept; i++) send_byte(stream[i], stall);
    #1 s_valid = 1'b0;
  endtask

  task automatic finish_stream();
    int t;
    if (m_accept < stream.size()) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = stream[m_accept];
      repeat (4) begin
        check("ignored_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
      end
      s_valid = 1'b0;
    end
    t = 0;
    while (m_wr.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("writes_drained", 32'(m_wr.size()), 32'd0);
    @(negedge clk);
    check("seg_count", 32'(seg_count), 32'(m_seg));
    check("load_err", 32'(load_err), 32'(m_err));
    check("load_done", 32'(load_done), 32'(m_done));
    check("cpu_run", 32'(cpu_run), 32'(m_done));
    check("pc_vec", 32'(pc_vec), 32'(m_vec));
    check("s_ready_idle", 32'(s_ready), 32'(!m_err && !m_done));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    cpu_addr = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_we = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_pc_vec", 32'(pc_vec), 32'h0400);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_seg", 32'(seg_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(s_ready), 32'd1);
    cpu_we = 1'b1;
    cpu_addr = 16'h1111;
    #1 check("cpu_we_ignored", 32'(mem_we), 32'd0);
    cpu_we = 1'b0;

    // DATA then GO
    stream = '{8'h01, 8'h00, 8'h04, 8'h02, 8'h00, 8'hA9, 8'h01, 8'h50, 8'h02, 8'h00, 8'h04};
    run_stream(1'b0);
    @(negedge clk);
    check("go_cpu_run", 32'(cpu_run), 32'd1);
    check("go_done", 32'(load_done), 32'd1);
    check("go_pc_vec", 32'(pc_vec), 32'h0400);
    finish_stream();
    check("ram_0400", 32'(ram[16'h0400]), 32'hA9);
    check("ram_0401", 32'(ram[16'h0401]), 32'h01);
    check("seg_one", 32'(seg_count), 32'd1);

    // FILL 16 bytes of EA at 0x0200
    do_reset();
    stream = '{8'h03, 8'h00, 8'h02, 8'h10, 8'h00, 8'hEA, 8'h04};
    run_stream(1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("fill_we", 32'(mem_we), 32'd1);
      check("fill_ready", 32'(s_ready), 32'd0);
    end
    @(negedge clk);
    check("fill_we_end", 32'(mem_we), 32'd0);
    check("fill_ready_end", 32'(s_ready), 32'd1);
    finish_stream();
    check("ram_0200", 32'(ram[16'h0200]), 32'hEA);
    check("ram_020F", 32'(ram[16'h020F]), 32'hEA);

    // Address wrap, then GO to a non-default vector, then reset from RUN
    do_reset();
    stream = '{8'h01, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'hCD, 8'h02, 8'h34, 8'h12};
    run_stream(1'b0);
    finish_stream();
    check("ram_FFFF", 32'(ram[16'hFFFF]), 32'h11);
    check("ram_0000", 32'(ram[16'h0000]), 32'h22);
    check("wrap_err", 32'(load_err), 32'd0);
    check("wrap_vec", 32'(pc_vec), 32'h1234);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("run_rst_cpu_run", 32'(cpu_run), 32'd0);
    check("run_rst_pc_vec", 32'(pc_vec), 32'h0400);
    rst = 1'b0;
    @(negedge clk);

    // Bad checksum: writes kept, later GO ignored
    do_reset();
    base = wr_cnt;
    stream = '{8'h01, 8'h00, 8'h04, 8'h02, 8'h00, 8'hA9, 8'h01, 8'h51, 8'h02, 8'h00, 8'h04};
    run_stream(1'b0);
    finish_stream();
    check("bad_cs_err", 32'(load_err), 32'd1);
    check("bad_cs_seg", 32'(seg_count), 32'd0);
    check("bad_cs_run", 32'(cpu_run), 32'd0);
    check("bad_cs_writes", 32'(wr_cnt - base), 32'd2);
    check("bad_cs_ram", 32'(ram[16'h0401]), 32'h01);

    // Bad type byte, then reset recovers
    do_reset();
    stream = '{8'h07, 8'h01, 8'h00};
    run_stream(1'b0);
    finish_stream();
    check("bad_type_ready", 32'(s_ready), 32'd0);
    check("bad_type_err", 32'(load_err), 32'd1);
    do_reset();
    check("recover_ready", 32'(s_ready), 32'd1);
    check("recover_err", 32'(load_err), 32'd0);

    // Stalled DATA record, GO, then CPU owns the port
    data_mode = 1'b1;
    base = wr_cnt;
    stream = '{8'h01, 8'h10, 8'h00, 8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hEC,
               8'h02, 8'h00, 8'h08};
    run_stream(1'b1);
    finish_stream();
    data_mode = 1'b0;
    check("stall_writes", 32'(wr_cnt - base), 32'd5);
    check("ram_0014", 32'(ram[16'h0014]), 32'h55);
    check("stall_vec", 32'(pc_vec), 32'h0800);
    cpu_addr = 16'h0010;
    cpu_wdata = 8'h5A;
    cpu_we = 1'b1;
    #1;
    check("mux_addr", 32'(mem_addr), 32'h0010);
    check("mux_wdata", 32'(mem_wdata), 32'h5A);
    check("mux_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    cpu_we = 1'b0;
    #1 check("mux_we_low", 32'(mem_we), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_preloader.md
# mem_preloader

Hardware program loader between a host byte stream and the shared system RAM port. It parses framed load records, writes them into RAM, and holds the 6502 core idle until a GO record arrives. Once the GO record arrives it hands the RAM port to the CPU and presents the start vector. It replaces testbench-driven memory muxing with synthesizable logic and adds segmented loads, fill records, checksums and error reporting.

## Interface
- ADDR_W, 16, RAM address width (9..16); address bytes above ADDR_W are truncated.
- DEFAULT_VEC, 16'h0400, pc_vec value from reset until a GO record is accepted.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_ready  out  1  loader accepts byte; handshake completes when s_valid and s_ready are both high on a clk edge
- cpu_addr  in  ADDR_W  CPU memory address
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write enable
- cpu_run  out  1  high releases CPU; low holds it in reset
- pc_vec  out  16  start vector for the CPU's pc_reset input
- load_done  out  1  GO accepted
- load_err  out  1  sticky error flag
- seg_count  out  8  good DATA and FILL records, saturating at 255

## Operation
- Record formats, multi-byte fields little-endian:
  - DATA: 0x01, addr_lo, addr_hi, len_lo, len_hi, len data bytes, csum.
  - FILL: 0x03, addr_lo, addr_hi, len_lo, len_hi, value, csum.
  - GO: 0x02, vec_lo, vec_hi. GO has no checksum.
- Checksum rule: the 8-bit sum of every byte after the type byte, including csum, must be 0x00.
- FSM states: HDR, ADDR_L, ADDR_H, LEN_L, LEN_H, DATA, VAL, CSUM, FILL, VEC_L, VEC_H, RUN, ERR.
- HDR transitions:
  - 0x01 or 0x03 → ADDR_L.
  - 0x02 → VEC_L.
  - Any other type → ERR.
- DATA record path:
  - LEN_H goes to DATA if len≠0, else to CSUM.
  - Each accepted data byte is written at the current address; the address then increments mod 2^ADDR_W.
  - After the len-th byte → CSUM.
- FILL record path:
  - LEN_H → VAL → CSUM.
  - After a good csum: → FILL if len≠0, else → HDR.
  - FILL writes value to len consecutive addresses, one per cycle, with address wrap mod 2^ADDR_W, then → HDR.
- CSUM outcome: a good csum increments seg_count. A bad csum sets load_err and → ERR.
- DATA bytes are written as they arrive. A bad csum does not undo writes already made.
- VEC_H accept: latches pc_vec = {vec_hi, vec_lo}, sets load_done and cpu_run, → RUN.
- RUN and ERR are terminal until rst; s_ready=0 in both.
- Port mux:
  - While cpu_run=1: mem_addr, mem_wdata and mem_we equal cpu_addr, cpu_wdata and cpu_we, combinationally.
  - Otherwise they carry the loader's registered outputs, and cpu_we is ignored.
- len counter is 16 bits and decrements; len=0xFFFF is legal.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, pc_vec=DEFAULT_VEC, load_done=0, load_err=0, seg_count=0, state=HDR.
- s_ready is registered:
  - 1 in the first cycle after rst deasserts.
  - 1 in every parsing state, 0 in FILL, RUN and ERR.
- Write latency: mem_we/mem_addr/mem_wdata are registered. A data-byte handshake on edge N produces mem_we=1 during cycle N+1.
- FILL latency: mem_we is high for exactly len consecutive cycles, starting the cycle after the csum handshake. s_ready returns to 1 in the cycle after the last write.
- GO latency: the VEC_H handshake on edge N gives cpu_run=1, load_done=1 and the new pc_vec in cycle N+1. The mux switches in the same cycle.
- Throughput: one byte per cycle with s_valid held high; no bubbles between records.
- s_valid low stalls any parsing state indefinitely with no side effects.
- Reset mid-record returns to HDR next cycle and clears flags; partial RAM contents are retained.
- rst while in RUN drops cpu_run the next cycle and reverts pc_vec to DEFAULT_VEC.

## Test plan
- DATA then GO: stream 01 00 04 02 00 A9 01 50 then 02 00 04 → RAM[0x0400]=A9 and RAM[0x0401]=01; seg_count=1; cpu_run=1 and pc_vec=0x0400 one cycle after the last byte.
- FILL: stream 03 00 02 10 00 EA 04 → 16 consecutive mem_we cycles writing EA to 0x0200..0x020F, with s_ready=0 for those 16 cycles.
- Wrap: stream 01 FF FF 02 00 11 22 CD with ADDR_W=16 → RAM[0xFFFF]=11 and RAM[0x0000]=22; no error.
- Bad checksum: first record with csum 51 → load_err=1, s_ready=0, seg_count=0, RAM[0x0400..0x0401] still written; a later 02 00 04 is ignored and cpu_run stays 0.
- Bad type: byte 0x07 in HDR → ERR; a following rst restores HDR, s_ready=1 and load_err=0.
- Handoff and stall: during a DATA record toggle s_valid randomly → writes occur only on handshakes. After GO, a CPU write to 0x0010 appears on mem_* in the same cycle.
